// File: rtl/oled_pkg.sv
// Shared definitions for the OLED command-sequencer arbiter.
package oled_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // 7-bit I2C address of the SSD1306-class panel.
  localparam logic [6:0] OLED_CHIP_ADDR = 7'h3C;

  // Default watchdog limit in clk cycles.
  localparam logic [19:0] DEF_TIMEOUT_CYCLES = 20'd1000000;

  // Well-known channel indices.
  localparam int CH_INIT = 0;
  localparam int CH_DISP = 1;

  // Increment a channel index with wrap at n (n need not be a power of 2).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/oled_seq_arb_rr_arbiter.sv
// Combinational channel picker: fixed priority or round-robin from rr_ptr.
module rr_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int ARB_MODE = 1
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [CH_W-1:0]   winner,
  output logic              valid
);

  int          base;
  int          idx;
  logic [CH_W-1:0] sel;

  // Scan upward from the base index with wrap; first set bit wins.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    sel    = '0;
    base   = (ARB_MODE == 0) ? 0 : int'(rr_ptr);
    for (int k = 0; k < NUM_CH; k++) begin
      idx = base + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = CH_W'(idx);
      if (!valid && pending[sel]) begin
        winner = sel;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_seq_arb.sv
// Arbitrates NUM_CH OLED command sequencers onto one i2c_master write port.
module oled_seq_arb
  import oled_pkg::*;
#(
  parameter int              NUM_CH         = 4,
  parameter int              CH_W           = 2,
  parameter int              ARB_MODE       = 1,
  parameter int              TO_W           = 20,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = TO_W'(DEF_TIMEOUT_CYCLES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   req,
  output logic [NUM_CH-1:0]   pending,
  output logic [NUM_CH-1:0]   ch_start,
  output logic [NUM_CH-1:0]   ch_abort,
  input  logic [NUM_CH-1:0]   ch_done,
  input  logic [NUM_CH*8-1:0] ch_reg_addr,
  input  logic [NUM_CH*8-1:0] ch_reg_data,
  input  logic [NUM_CH-1:0]   ch_write_en,
  output logic [NUM_CH-1:0]   ch_i2c_done,
  output logic [7:0]          i2c_reg_addr,
  output logic [7:0]          i2c_reg_data,
  output logic                i2c_write_en,
  input  logic                i2c_done,
  output logic                busy,
  output logic                done,
  output logic [CH_W-1:0]     done_ch,
  output logic                timeout,
  output logic [CH_W-1:0]     grant
);

  logic [NUM_CH-1:0] sync1, sync2, sync3, rise;
  logic [NUM_CH-1:0] grant_oh, pend_clr;
  logic [CH_W-1:0]   rr_ptr, win;
  logic              win_vld, grant_done, hit_timeout;
  logic [TO_W-1:0]   wd;
  state_t            state, state_nxt;

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .CH_W     (CH_W),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .winner  (win),
    .valid   (win_vld)
  );

  assign rise        = sync2 & ~sync3;
  assign grant_oh    = NUM_CH'(1) << grant;
  assign grant_done  = ch_done[grant];
  assign busy        = (state != ST_IDLE);
  // ch_done beats the watchdog when both land in the same cycle.
  assign hit_timeout = (state == ST_RUN) && (wd == TIMEOUT_CYCLES - TO_W'(1))
                       && !i2c_done && !grant_done;

  // Two-flop synchroniser plus edge register for the request levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so the chain shifts one stage per clock.
      sync1 <= req;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and decoded per-state outputs, including the RUN-only mux.
  always_comb begin
    state_nxt    = state;
    ch_start     = '0;
    ch_abort     = '0;
    ch_i2c_done  = '0;
    i2c_reg_addr = 8'h00;
    i2c_reg_data = 8'h00;
    i2c_write_en = 1'b0;
    done         = 1'b0;
    timeout      = 1'b0;
    pend_clr     = '0;
    case (state)
      ST_IDLE: if (win_vld) state_nxt = ST_START;
      ST_START: begin
        ch_start  = grant_oh;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        i2c_reg_addr = ch_reg_addr[int'(grant)*8 +: 8];
        i2c_reg_data = ch_reg_data[int'(grant)*8 +: 8];
        i2c_write_en = ch_write_en[grant];
        ch_i2c_done  = grant_oh & {NUM_CH{i2c_done}};
        if (grant_done) begin
          state_nxt = ST_FIN;
        end else if (hit_timeout) begin
          ch_abort  = grant_oh;
          timeout   = 1'b1;
          pend_clr  = grant_oh;
          state_nxt = ST_IDLE;
        end
      end
      ST_FIN: begin
        done      = 1'b1;
        pend_clr  = grant_oh;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pending queue, grant, round-robin pointer, completion index and watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      grant   <= '0;
      rr_ptr  <= '0;
      done_ch <= '0;
      wd      <= '0;
    end else begin
      // A fresh edge overrides a same-cycle clear so the channel is served again.
      pending <= (pending & ~pend_clr) | rise;
      if (state == ST_IDLE && win_vld) grant <= win;
      if (state == ST_FIN) rr_ptr <= CH_W'(wrap_inc(int'(grant), NUM_CH));
      if ((state == ST_RUN && grant_done) || hit_timeout) done_ch <= grant;
      if (state == ST_START) begin
        wd <= '0;
      end else if (state == ST_RUN) begin
        if (i2c_done)     wd <= '0;
        else if (wd != '1) wd <= wd + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_oled_seq_arb.sv
// Self-checking bench for oled_seq_arb: directed scenarios plus randomized service rounds.
module tb_oled_seq_arb;

  localparam int N   = 4;
  localparam int ARB = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Round-robin DUT signals.
  logic [N-1:0]   req, pending, ch_start, ch_abort, ch_done, ch_write_en, ch_i2c_done;
  logic [N*8-1:0] ch_reg_addr, ch_reg_data;
  logic [7:0]     i2c_reg_addr, i2c_reg_data;
  logic           i2c_write_en, i2c_done, busy, done, timeout;
  logic [1:0]     done_ch, grant;

  // Fixed-priority DUT signals.
  logic [N-1:0]   fp_req, fp_pending, fp_ch_start, fp_ch_abort, fp_ch_done, fp_ch_i2c_done;
  logic [7:0]     fp_i2c_reg_addr, fp_i2c_reg_data;
  logic           fp_i2c_write_en, fp_busy, fp_done, fp_timeout;
  logic [1:0]     fp_done_ch, fp_grant;

  oled_seq_arb #(
    .NUM_CH(N), .CH_W(2), .ARB_MODE(ARB), .TO_W(20), .TIMEOUT_CYCLES(20'd16)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .pending(pending),
    .ch_start(ch_start), .ch_abort(ch_abort), .ch_done(ch_done),
    .ch_reg_addr(ch_reg_addr), .ch_reg_data(ch_reg_data), .ch_write_en(ch_write_en),
    .ch_i2c_done(ch_i2c_done), .i2c_reg_addr(i2c_reg_addr), .i2c_reg_data(i2c_reg_data),
    .i2c_write_en(i2c_write_en), .i2c_done(i2c_done), .busy(busy), .done(done),
    .done_ch(done_ch), .timeout(timeout), .grant(grant)
  );

  oled_seq_arb #(
    .NUM_CH(N), .CH_W(2), .ARB_MODE(0), .TO_W(20), .TIMEOUT_CYCLES(20'd16)
  ) dut_fp (
    .clk(clk), .reset(reset), .req(fp_req), .pending(fp_pending),
    .ch_start(fp_ch_start), .ch_abort(fp_ch_abort), .ch_done(fp_ch_done),
    .ch_reg_addr('0), .ch_reg_data('0), .ch_write_en('0),
    .ch_i2c_done(fp_ch_i2c_done), .i2c_reg_addr(fp_i2c_reg_addr), .i2c_reg_data(fp_i2c_reg_data),
    .i2c_write_en(fp_i2c_write_en), .i2c_done(1'b0), .busy(fp_busy), .done(fp_done),
    .done_ch(fp_done_ch), .timeout(fp_timeout), .grant(fp_grant)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queued channels and the round-robin pointer.
  logic [N-1:0] m_pending;
  int           m_rr;

  // Fixed-priority side: a sequencer that finishes 6 cycles after its start pulse.
  int fp_cnt = 0;
  int fp_idx = 0;
  int fp_log[$];

  always @(negedge clk) begin
    fp_ch_done = '0;
    if (fp_ch_start != 0) begin
      for (int i = 0; i < N; i++) if (fp_ch_start[i]) fp_idx = i;
      fp_log.push_back(fp_idx);
      fp_cnt = 6;
    end else if (fp_cnt != 0) begin
      fp_cnt = fp_cnt - 1;
      if (fp_cnt == 0) fp_ch_done[fp_idx] = 1'b1;
    end
  end

  function automatic logic [N-1:0] oh(input int c);
    return N'(1) << c;
  endfunction

  // Next channel to serve by the arbitration rule.
  function automatic int model_winner(input logic [N-1:0] mask, input int ptr);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (ARB == 0) ? k : (ptr + k) % N;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req = '0; ch_done = '0; ch_write_en = '0; i2c_done = 1'b0; fp_req = '0;
    ch_reg_addr = '0; ch_reg_data = '0;
    reset = 1'b0;
    tick; tick;
    reset = 1'b1;
    m_pending = '0;
    m_rr = 0;
    tick;
  endtask

  task automatic req_rise(input logic [N-1:0] mask);
    req = req | mask;
    tick; tick;
    req = req & ~mask;
  endtask

  task automatic wait_start;
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick;
      if (ch_start != 0) seen = 1'b1;
    end
    check("start_seen", seen, 1'b1);
  endtask

  // Act as the granted sequencer: nbytes writes, then ch_done; optionally re-edge req in the FIN collision cycle.
  task automatic serve(input int g, input int nbytes, input bit fixed, input bit started, input bit reedge);
    logic [7:0] a, d;
    int lat;
    if (!started) wait_start;
    check("ch_start", ch_start, oh(g));
    check("grant", grant, g);
    check("busy_start", busy, 1'b1);
    ch_write_en = '1;
    ch_reg_addr = {$urandom, $urandom};
    #1;
    check("wen_outside_run", i2c_write_en, 1'b0);
    check("addr_outside_run", i2c_reg_addr, 8'h00);
    tick;
    ch_write_en = '0;
    for (int b = 0; b < nbytes; b++) begin
      a = fixed ? 8'h00 : 8'($urandom);
      d = fixed ? 8'hAE : 8'($urandom);
      ch_reg_addr = {$urandom, $urandom};
      ch_reg_data = {$urandom, $urandom};
      ch_reg_addr[g*8 +: 8] = a;
      ch_reg_data[g*8 +: 8] = d;
      ch_write_en = N'($urandom) | oh(g);
      #1;
      check("i2c_write_en", i2c_write_en, 1'b1);
      check("i2c_reg_addr", i2c_reg_addr, a);
      check("i2c_reg_data", i2c_reg_data, d);
      tick;
      ch_write_en = N'($urandom) & ~oh(g);
      lat = $urandom_range(0, 3);
      repeat (lat) begin
        ch_done = N'($urandom) & ~oh(g);
        tick;
      end
      ch_done = '0;
      ch_write_en = '0;
      check("busy_run", busy, 1'b1);
      i2c_done = 1'b1;
      #1;
      check("ch_i2c_done", ch_i2c_done, oh(g));
      tick;
      i2c_done = 1'b0;
    end
    if (reedge) begin
      req[g] = 1'b1;
      tick;
    end
    ch_done = oh(g);
    tick;
    ch_done = '0;
    req = '0;
    check("done_pulse", done, 1'b1);
    check("done_ch", done_ch, g);
    tick;
    check("done_low", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    if (!reedge) m_pending[g] = 1'b0;
    m_rr = (g + 1) % N;
    check("pending_after", pending, m_pending);
  endtask

  initial begin
    logic [N-1:0] mask;
    int guard;

    do_reset;
    check("rst_busy", busy, 1'b0);
    check("rst_pending", pending, '0);
    check("rst_grant", grant, 2'd0);
    check("rst_i2c_we", i2c_write_en, 1'b0);

    // Asynchronous reset in the middle of channel 1's RUN.
    req_rise(4'b0010);
    wait_start;
    check("t1_start", ch_start, 4'b0010);
    tick;
    ch_write_en = 4'b0010;
    #1;
    reset = 1'b0;
    #1;
    check("t1_busy", busy, 1'b0);
    check("t1_we", i2c_write_en, 1'b0);
    check("t1_pending", pending, '0);
    ch_write_en = '0;
    tick; tick;
    reset = 1'b1;
    m_pending = '0;
    m_rr = 0;
    repeat (8) tick;
    check("t1_no_grant_busy", busy, 1'b0);
    check("t1_no_grant_pend", pending, '0);

    // Single request on channel 0: capture latency and a fixed byte.
    req[0] = 1'b1;
    tick;
    check("t2_pend_c1", pending, '0);
    tick;
    check("t2_pend_c2", pending, '0);
    req[0] = 1'b0;
    tick;
    check("t2_pend_c3", pending, 4'b0001);
    check("t2_idle_c3", busy, 1'b0);
    tick;
    m_pending = 4'b0001;
    serve(0, 1, 1'b1, 1'b1, 1'b0);

    // Round-robin from rr_ptr = 0: triple then pair.
    do_reset;
    req_rise(4'b1101);
    m_pending = 4'b1101;
    serve(0, 1, 1'b0, 1'b0, 1'b0);
    serve(2, 2, 1'b0, 1'b0, 1'b0);
    serve(3, 1, 1'b0, 1'b0, 1'b0);
    check("t3_rr_wrapped", m_rr, 0);
    req_rise(4'b1001);
    m_pending = 4'b1001;
    serve(0, 1, 1'b0, 1'b0, 1'b0);
    serve(3, 1, 1'b0, 1'b0, 1'b0);

    // Re-edge on channel 1 that lands on the FIN clear: served twice.
    req_rise(4'b0010);
    m_pending = m_pending | 4'b0010;
    serve(1, 1, 1'b0, 1'b0, 1'b1);
    check("t6_pend_kept", pending[1], 1'b1);
    serve(1, 2, 1'b0, 1'b0, 1'b0);

    // Watchdog: channel 2 never sees i2c_done.
    req_rise(4'b1100);
    m_pending = m_pending | 4'b1100;
    wait_start;
    check("t5_start", ch_start, oh(model_winner(m_pending, m_rr)));
    check("t5_start_ch2", ch_start, 4'b0100);
    tick;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) tick;
      check("t5_timeout", timeout, (k == 16));
      check("t5_abort", ch_abort, (k == 16) ? 4'b0100 : 4'b0000);
    end
    tick;
    m_pending[2] = 1'b0;
    check("t5_timeout_low", timeout, 1'b0);
    check("t5_idle", busy, 1'b0);
    check("t5_done_ch", done_ch, 2'd2);
    check("t5_pending", pending, m_pending);
    serve(model_winner(m_pending, m_rr), 1, 1'b0, 1'b0, 1'b0);

    // Randomized service rounds checked against the model.
    for (int r = 0; r < 8; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      req_rise(mask);
      m_pending = m_pending | mask;
      guard = 0;
      while (m_pending != 0 && guard < N) begin
        serve(model_winner(m_pending, m_rr), $urandom_range(1, 3), 1'b0, 1'b0, 1'b0);
        guard++;
      end
    end

    // Fixed priority: triple, then channel 1 arrives during channel 2's RUN.
    fp_req = 4'b1101;
    for (int n = 0; n < 100 && fp_log.size() < 2; n++) tick;
    fp_req = 4'b1111;
    for (int n = 0; n < 200 && fp_log.size() < 4; n++) tick;
    check("fp_count", fp_log.size(), 4);
    check("fp_order0", (fp_log.size() > 0) ? fp_log[0] : -1, 0);
    check("fp_order1", (fp_log.size() > 1) ? fp_log[1] : -1, 2);
    check("fp_order2", (fp_log.size() > 2) ? fp_log[2] : -1, 1);
    check("fp_order3", (fp_log.size() > 3) ? fp_log[3] : -1, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
